radar_scan_sequencer: RTL
=========================

// Module: radar_scan_sequencer
// PURPOSE
// - Upstream controller for the radar top: drives its Enable_SM/Enable_US/Period/Dutty inputs, consumes Done/Led.
// - Sweeps the servo through N_STEPS positions; at each, waits for settling, fires one ultrasonic measurement, stores the 8-bit distance.
// - Results are held in an N_STEPS x 8 result table, readable by the CPU/display side at any time.
// PARAMETERS
// - N_STEPS      8         positions per sweep (2..16); servo duty code = step index
// - SETTLE_CYC   25000000  clk cycles held in SETTLE after each servo move
// - SM_PERIOD    8'd20     period code sent while servo active
// - US_PERIOD    8'd60     period code sent while ultrasonic active
// - US_DUTTY     4'd1      duty code sent while ultrasonic active
// - TIMEOUT_CYC  3000000   measurement timeout in clk cycles (used only with SCAN_TIMEOUT_EN)
// PORTS
// - clk          in   1   system clock
// - rst          in   1   asynchronous, active-high reset
// - start        in   1   1-cycle pulse: begin sweep (ignored unless IDLE)
// - continuous   in   1   1: restart a new sweep immediately after completion
// - enable_sm    out  1   to radar Enable_SM
// - enable_us    out  1   to radar Enable_US
// - period       out  8   to radar Period
// - dutty        out  4   to radar Dutty
// - us_done      in   1   from radar Done (level, slower clock domain)
// - us_dist      in   8   from radar Led (distance code, valid when us_done high)
// - rd_addr      in   4   result table read index
// - rd_data      out  8   result table word at rd_addr (registered, 1-cycle latency)
// - step_idx     out  4   current step index
// - busy         out  1   high in every state except IDLE
// - sweep_done   out  1   1-cycle pulse when the last step of a sweep is stored
// - timeout_err  out  1   sticky; set on measurement timeout (tied 0 without SCAN_TIMEOUT_EN)
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, step_idx 0, direction up, result table cleared to 8'h00.
// - us_done passes through a 2-FF synchronizer, then rising-edge detect -> done_pulse (3-cycle latency).
// - FSM: IDLE -> MOVE -> SETTLE -> GAP -> MEASURE -> STORE -> NEXT.
//   - IDLE: all drives 0; start=1 -> MOVE.
//   - MOVE (1 cycle): enable_sm=1, period=SM_PERIOD, dutty=step_idx; load settle counter.
//   - SETTLE: enable_sm held 1, same codes; counter reaches SETTLE_CYC-1 -> GAP.
//   - GAP (1 cycle): all drives 0; guarantees enable_sm and enable_us are never both high.
//   - MEASURE: enable_us=1, period=US_PERIOD, dutty=US_DUTTY; done_pulse -> STORE.
//   - STORE (1 cycle): table[step_idx] <= us_dist sampled on the done_pulse cycle; drives 0.
//   - NEXT (1 cycle): last step of sweep -> pulse sweep_done; then IDLE, or MOVE if continuous=1.
//     Otherwise step_idx +/-1 -> MOVE.
// - Direction ping-pong: up sweep 0..N_STEPS-1, then down N_STEPS-1..0; end steps are not repeated
//   inside one sweep, but the end step starts the next sweep (the servo does not jump back).
// - A done_pulse outside MEASURE is ignored. start while busy is ignored.
// - continuous sampled only in NEXT; deasserting mid-sweep finishes the current sweep.
// - Reset mid-operation: immediate return to IDLE, drives 0, table cleared.
// - Read port independent of FSM; write and read of same address in one cycle returns the old value.
// - rd_addr >= N_STEPS returns 8'h00.
// CONFIGURATION
// - SCAN_TIMEOUT_EN defined: MEASURE counts cycles; on reaching TIMEOUT_CYC with no done_pulse ->
//   STORE writes 8'hFF, timeout_err set (sticky until rst), sweep continues normally.
// - SCAN_TIMEOUT_EN undefined: MEASURE waits indefinitely; timeout counter not built; timeout_err=0.
// TESTING (SETTLE_CYC=10, TIMEOUT_CYC=50, N_STEPS=4 in bench)
// - rst held then released, no start -> all outputs 0, busy 0, rd_data 0 for every rd_addr.
// - start pulse, us_done model answers 20 cycles after enable_us rises with dist 10,20,30,40 ->
//   dutty on the MOVE steps = 0,1,2,3; table = {10,20,30,40}; one sweep_done pulse; back to IDLE.
// - Check every cycle of the sweep: enable_sm & enable_us never both 1; GAP lasts exactly 1 cycle.
// - continuous=1, two sweeps -> second sweep step order 3,2,1,0; table overwritten in that order.
// - rst asserted during MEASURE -> same cycle enable_us=0, busy=0; table reads 0.
// - SCAN_TIMEOUT_EN, model never raises us_done at step 2 -> after 50 cycles table[2]=8'hFF,
//   timeout_err=1, step 3 still measured; without macro FSM stays in MEASURE.

Source files
------------

// File: rtl/radar_scan_sequencer_if.sv
// Radar-side bundle of the scan sequencer: servo/ultrasonic drive codes
// going out, measurement done flag and distance code coming back.
interface radar_scan_sequencer_if;
  logic       enable_sm;
  logic       enable_us;
  logic [7:0] period;
  logic [3:0] dutty;
  logic       us_done;
  logic [7:0] us_dist;

  modport master (
    output enable_sm, enable_us, period, dutty,
    input  us_done, us_dist
  );

  modport slave (
    input  enable_sm, enable_us, period, dutty,
    output us_done, us_dist
  );
endinterface

// File: rtl/radar_scan_sequencer.sv
// Radar scan sequencer: sweeps the servo across N_STEPS positions in a
// ping-pong pattern, lets each move settle, fires one ultrasonic
// measurement per position and stores the distance in a result table.
// Optional feature macro: SCAN_TIMEOUT_EN (measurement timeout writes
// 8'hFF and sets the sticky timeout_err flag).
module radar_scan_sequencer #(
  parameter int         N_STEPS     = 8,
  parameter int         SETTLE_CYC  = 25000000,
  parameter logic [7:0] SM_PERIOD   = 8'd20,
  parameter logic [7:0] US_PERIOD   = 8'd60,
  parameter logic [3:0] US_DUTTY    = 4'd1,
  parameter int         TIMEOUT_CYC = 3000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          continuous,
  radar_scan_sequencer_if.master        radar,
  input  logic [3:0]                    rd_addr,
  output logic [7:0]                    rd_data,
  output logic [3:0]                    step_idx,
  output logic                          busy,
  output logic                          sweep_done,
  output logic                          timeout_err
);

  localparam int AW = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_MOVE, S_SETTLE, S_GAP, S_MEASURE, S_STORE, S_NEXT
  } state_t;

  state_t      state, next_state;
  logic        sync1, sync2, sync3;
  logic        done_pulse;
  logic [31:0] settle_cnt;
  logic        settle_done;
  logic        dir_up;
  logic        last_step;
  logic        meas_timeout;
  logic [7:0]  dist_reg;
  logic [7:0]  result_mem [N_STEPS];
  logic        sm_en, us_en, sweep_pulse;
  logic [7:0]  period_c;
  logic [3:0]  dutty_c;

  // Bring the slow-domain done level into clk and keep one extra stage for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= radar.us_done;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign done_pulse = sync2 & ~sync3;

  // Settle counter restarts on every servo move and runs through SETTLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) settle_cnt <= '0;
    else if (state == S_MOVE) settle_cnt <= '0;
    else if (state == S_SETTLE) settle_cnt <= settle_cnt + 32'd1;
  end

  assign settle_done = (settle_cnt == 32'(SETTLE_CYC - 1));
  assign last_step   = dir_up ? (step_idx == 4'(N_STEPS - 1)) : (step_idx == 4'd0);

`ifdef SCAN_TIMEOUT_EN
  logic [31:0] meas_cnt;

  // Count cycles spent waiting for a measurement; cleared outside MEASURE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) meas_cnt <= '0;
    else if (state != S_MEASURE) meas_cnt <= '0;
    else meas_cnt <= meas_cnt + 32'd1;
  end

  assign meas_timeout = (state == S_MEASURE) && !done_pulse &&
                        (meas_cnt == 32'(TIMEOUT_CYC - 1));

  // Sticky timeout flag, only cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) timeout_err <= 1'b0;
    else if (meas_timeout) timeout_err <= 1'b1;
  end
`else
  assign meas_timeout = 1'b0;
  assign timeout_err  = 1'b0;
`endif

  // Capture the distance on the done pulse, or the timeout marker
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dist_reg <= 8'h00;
    else if (state == S_MEASURE && done_pulse) dist_reg <= radar.us_dist;
    else if (meas_timeout) dist_reg <= 8'hFF;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else state <= next_state;
  end

  // Next-state and radar drive decode; servo and ultrasonic never share a state
  always_comb begin
    next_state  = state;
    sm_en       = 1'b0;
    us_en       = 1'b0;
    period_c    = 8'h00;
    dutty_c     = 4'h0;
    sweep_pulse = 1'b0;
    case (state)
      S_IDLE: if (start) next_state = S_MOVE;
      S_MOVE: begin
        sm_en      = 1'b1;
        period_c   = SM_PERIOD;
        dutty_c    = step_idx;
        next_state = S_SETTLE;
      end
      S_SETTLE: begin
        sm_en    = 1'b1;
        period_c = SM_PERIOD;
        dutty_c  = step_idx;
        if (settle_done) next_state = S_GAP;
      end
      S_GAP: next_state = S_MEASURE;
      S_MEASURE: begin
        us_en    = 1'b1;
        period_c = US_PERIOD;
        dutty_c  = US_DUTTY;
        if (done_pulse || meas_timeout) next_state = S_STORE;
      end
      S_STORE: next_state = S_NEXT;
      S_NEXT: begin
        if (last_step) begin
          sweep_pulse = 1'b1;
          next_state  = continuous ? S_MOVE : S_IDLE;
        end else begin
          next_state = S_MOVE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  assign radar.enable_sm = sm_en;
  assign radar.enable_us = us_en;
  assign radar.period    = period_c;
  assign radar.dutty     = dutty_c;
  assign busy            = (state != S_IDLE);
  assign sweep_done      = sweep_pulse;

  // Step/direction ping-pong: the end step flips direction and starts the next sweep
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_idx <= 4'd0;
      dir_up   <= 1'b1;
    end else if (state == S_NEXT) begin
      if (last_step) dir_up <= ~dir_up;
      else if (dir_up) step_idx <= step_idx + 4'd1;
      else step_idx <= step_idx - 4'd1;
    end
  end

  // Result table write; cleared on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_STEPS; i++) result_mem[i] <= 8'h00;
    end else if (state == S_STORE) begin
      result_mem[step_idx[AW-1:0]] <= dist_reg;
    end
  end

  // Registered read port; out-of-range addresses read as zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= 8'h00;
    else if ({28'd0, rd_addr} < 32'(N_STEPS)) rd_data <= result_mem[rd_addr[AW-1:0]];
    else rd_data <= 8'h00;
  end

endmodule
